// File: rtl/pixel_reader.sv
// pixel_reader: framebuffer fetch stage. Issues Avalon-MM burst reads over a
// linear 32-bit-per-pixel framebuffer and streams the pixels out as Avalon-ST.
//
// Ports:
//   in_clk, in_reset        clock, asynchronous active-high reset
//   in_next_frame           frame advance level; its rising edge restarts fetch
//   out_mem_*, in_mem_*     Avalon-MM burst read master
//   out_pixel_data/valid    Avalon-ST source, FIFO head (show-ahead)
//   in_pixel_ready          sink accepts the pixel
module pixel_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          WIDTH      = 800,
    parameter int          HEIGHT     = 480,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         in_next_frame,
    output logic [31:0]                  out_mem_address,
    output logic                         out_mem_read,
    output logic [$clog2(BURST_LEN):0]   out_mem_burstcount,
    input  logic                         in_mem_waitrequest,
    input  logic [31:0]                  in_mem_readdata,
    input  logic                         in_mem_readdatavalid,
    output logic [23:0]                  out_pixel_data,
    output logic                         out_pixel_valid,
    input  logic                         in_pixel_ready
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int REQ_W = $clog2(TOTAL + 1);
    localparam int OUT_W = $clog2(FIFO_DEPTH + BURST_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = OUT_W + 2;
    localparam int BC_W  = $clog2(BURST_LEN) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state;
    logic             prev;
    logic [REQ_W-1:0] requested;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] out_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [23:0]      fifo_mem [FIFO_DEPTH];

    logic next_edge;
    logic accept;
    logic push;
    logic pop;
    logic more;
    logic last_burst;
    logic credit_ok;
    logic unused_hi;

    assign out_mem_burstcount = BC_W'(BURST_LEN);
    assign unused_hi = ^in_mem_readdata[31:24];

    assign next_edge  = in_next_frame & ~prev;
    assign accept     = out_mem_read & ~in_mem_waitrequest;
    assign more       = requested < REQ_W'(TOTAL);
    assign last_burst = requested == REQ_W'(TOTAL - BURST_LEN);

    // Outstanding beats are reserved FIFO space, so the FIFO can never overflow.
    assign credit_ok = SUM_W'(fifo_count) + SUM_W'(outstanding)
                       + SUM_W'(BURST_LEN) <= SUM_W'(FIFO_DEPTH);

    // Beats of an abandoned frame are dropped while flushing or on the restart edge.
    assign push = in_mem_readdatavalid & (state != ST_FLUSH) & ~next_edge;
    assign pop  = out_pixel_valid & in_pixel_ready & ~next_edge;

    always_comb begin
        out_nxt = outstanding;
        if (accept)
            out_nxt = out_nxt + OUT_W'(BURST_LEN);
        if (in_mem_readdatavalid)
            out_nxt = out_nxt - OUT_W'(1);
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            prev            <= 1'b0;
            state           <= ST_IDLE;
            requested       <= '0;
            outstanding     <= '0;
            out_mem_read    <= 1'b0;
            out_mem_address <= BASE_ADDR;
        end else begin
            prev        <= in_next_frame;
            outstanding <= out_nxt;
            if (next_edge) begin
                requested       <= '0;
                out_mem_address <= BASE_ADDR;
                out_mem_read    <= 1'b0;
                if (state == ST_FLUSH || out_nxt != '0)
                    state <= ST_FLUSH;
                else
                    state <= ST_FETCH;
            end else begin
                if (accept) begin
                    out_mem_read    <= 1'b0;
                    out_mem_address <= out_mem_address + 32'(4 * BURST_LEN);
                    requested       <= requested + REQ_W'(BURST_LEN);
                end
                case (state)
                    ST_FETCH: begin
                        if (accept && last_burst)
                            state <= ST_IDLE;
                        else if (!out_mem_read && more && credit_ok)
                            out_mem_read <= 1'b1;
                    end
                    ST_FLUSH: begin
                        if (outstanding == '0)
                            state <= ST_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (next_edge) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge in_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= in_mem_readdata[23:0];
    end

    assign out_pixel_data  = fifo_mem[rd_ptr];
    assign out_pixel_valid = fifo_count != '0;

endmodule

// File: tb/tb_pixel_reader.sv
// tb_pixel_reader: directed bench for pixel_reader with a small Avalon-MM
// memory model (2-cycle latency, word = addr/4) and an in-order pixel sink.
module tb_pixel_reader;

    localparam int          W     = 4;
    localparam int          H     = 2;
    localparam int          BL    = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk;
    logic        in_reset;
    logic        in_next_frame;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [2:0]  mem_burstcount;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    pixel_reader #(
        .BASE_ADDR  (BASE),
        .WIDTH      (W),
        .HEIGHT     (H),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .in_clk               (clk),
        .in_reset             (in_reset),
        .in_next_frame        (in_next_frame),
        .out_mem_address      (mem_address),
        .out_mem_read         (mem_read),
        .out_mem_burstcount   (mem_burstcount),
        .in_mem_waitrequest   (mem_waitrequest),
        .in_mem_readdata      (mem_readdata),
        .in_mem_readdatavalid (mem_readdatavalid),
        .out_pixel_data       (pixel_data),
        .out_pixel_valid      (pixel_valid),
        .in_pixel_ready       (pixel_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    int          ready_mode = 1;
    int          hold_idx = -1;
    int          hold_len = 0;
    int          hold_cnt = 0;
    bit          wr_rand = 1'b0;
    bit          edge_pending = 1'b0;
    int          out_m = 0;
    int          occ_m = 0;
    int          discard_m = 0;
    int          viol = 0;
    int          f_bursts = 0;
    int          f_pops = 0;
    int          out_at_first = -1;
    int          rd_cycles = 0;
    int          rd_at_acc = -1;
    int          last_t = 0;
    logic [31:0] b_addr [8];
    logic [23:0] exp_px = 24'h40;
    logic [31:0] q_word [$];
    int          q_time [$];
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    // Memory model and pixel sink: everything for the coming posedge is
    // decided on the falling edge, so DUT inputs never move near sampling.
    initial forever begin
        int t;
        @(negedge clk);
        cyc++;
        if (in_reset) begin
            q_word.delete();
            q_time.delete();
            out_m = 0; occ_m = 0; discard_m = 0;
            f_bursts = 0; f_pops = 0; hold_cnt = 0; last_t = 0;
            prev_hold = 1'b0;
            mem_readdatavalid = 1'b0;
            mem_waitrequest = 1'b0;
            continue;
        end
        if (prev_hold) begin
            check("hold_read", {31'd0, mem_read}, 32'd1);
            check("hold_addr", mem_address, prev_addr);
        end
        if (mem_read && f_bursts == hold_idx && hold_cnt < hold_len) begin
            mem_waitrequest = 1'b1;
            hold_cnt++;
        end else if (wr_rand)
            mem_waitrequest = ($urandom_range(0, 2) == 0);
        else
            mem_waitrequest = 1'b0;
        if (mem_read && f_bursts == 0)
            rd_cycles++;
        prev_hold = mem_read && mem_waitrequest;
        prev_addr = mem_address;
        if (mem_read && !mem_waitrequest) begin
            if (f_bursts == 0) begin
                out_at_first = out_m;
                rd_at_acc = rd_cycles;
            end
            if (f_bursts < 8)
                b_addr[f_bursts] = mem_address;
            f_bursts++;
            t = (cyc + 2 > last_t + 1) ? cyc + 2 : last_t + 1;
            for (int i = 0; i < BL; i++) begin
                q_word.push_back({8'hA5, 24'(mem_address >> 2) + 24'(i)});
                q_time.push_back(t + i);
            end
            last_t = t + BL - 1;
            out_m += BL;
        end
        if (q_time.size() > 0 && q_time[0] <= cyc) begin
            mem_readdatavalid = 1'b1;
            mem_readdata = q_word.pop_front();
            void'(q_time.pop_front());
            out_m--;
            if (discard_m > 0)
                discard_m--;
            else
                occ_m++;
        end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata = 32'hDEAD_BEEF;
        end
        case (ready_mode)
            0:       pixel_ready = 1'b0;
            1:       pixel_ready = 1'b1;
            2:       pixel_ready = 1'($urandom_range(0, 1));
            default: pixel_ready = (f_pops < 3);
        endcase
        if (edge_pending) begin
            occ_m = 0;
            discard_m = out_m;
            exp_px = 24'h40;
            f_pops = 0;
            f_bursts = 0;
            rd_cycles = 0;
            hold_cnt = 0;
            edge_pending = 1'b0;
        end else if (pixel_valid && pixel_ready) begin
            check("pixel", {8'd0, pixel_data}, {8'd0, exp_px});
            exp_px++;
            f_pops++;
            occ_m--;
        end
        if (occ_m + out_m > DEPTH)
            viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        edge_pending = 1'b1;
        in_next_frame = 1'b1;
        tick();
        in_next_frame = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int limit, input string tag);
        int k = 0;
        while (f_pops < n && k < limit) begin
            tick();
            k++;
        end
        check(tag, f_pops, n);
    endtask

    initial begin
        int k;
        int reads;
        in_reset = 1'b1;
        in_next_frame = 1'b0;
        pixel_ready = 1'b1;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", {31'd0, mem_read}, 32'd0);
        check("rst_valid", {31'd0, pixel_valid}, 32'd0);
        check("rst_addr", mem_address, BASE);
        check("burstcount", {29'd0, mem_burstcount}, 32'd4);
        in_reset = 1'b0;
        tick();

        // 1: reset in the middle of a held second burst
        hold_idx = 1; hold_len = 50;
        kick();
        k = 0;
        while (!(mem_read && pixel_valid) && k < 100) begin
            tick();
            k++;
        end
        check("t1_mid_burst", {31'd0, mem_read && pixel_valid}, 32'd1);
        check("t1_addr_pre", mem_address, 32'h110);
        #2 in_reset = 1'b1;
        #1;
        check("t1_read", {31'd0, mem_read}, 32'd0);
        check("t1_valid", {31'd0, pixel_valid}, 32'd0);
        check("t1_addr", mem_address, BASE);
        hold_idx = -1; hold_len = 0;
        tick(); tick();
        in_reset = 1'b0;
        reads = 0;
        repeat (10) begin
            tick();
            if (mem_read) reads++;
        end
        check("t1_no_req", reads, 0);

        // 2: whole frame with ready=1
        ready_mode = 1;
        kick();
        wait_pops(8, 200, "t2_pixels");
        repeat (20) tick();
        check("t2_bursts", f_bursts, 2);
        check("t2_addr0", b_addr[0], 32'h100);
        check("t2_addr1", b_addr[1], 32'h110);
        check("t2_idle_read", {31'd0, mem_read}, 32'd0);
        check("t2_valid", {31'd0, pixel_valid}, 32'd0);
        check("t2_pops", f_pops, 8);

        // 3: sink stalled, credits stop the fetch at a full FIFO
        ready_mode = 0;
        kick();
        repeat (60) tick();
        check("t3_bursts", f_bursts, 2);
        check("t3_valid", {31'd0, pixel_valid}, 32'd1);
        check("t3_read", {31'd0, mem_read}, 32'd0);
        check("t3_occ", occ_m, 8);
        ready_mode = 1;
        wait_pops(8, 100, "t3_pixels");

        // 4: first burst held by waitrequest for 5 cycles
        hold_idx = 0; hold_len = 5;
        kick();
        k = 0;
        while (!mem_read && k < 50) begin
            tick();
            k++;
        end
        check("t4_read_seen", {31'd0, mem_read}, 32'd1);
        repeat (5) begin
            check("t4_read", {31'd0, mem_read}, 32'd1);
            check("t4_addr", mem_address, 32'h100);
            check("t4_bc", {29'd0, mem_burstcount}, 32'd4);
            tick();
        end
        check("t4_still_held", f_bursts, 0);
        tick();
        check("t4_read_drop", {31'd0, mem_read}, 32'd0);
        check("t4_accept_cyc", rd_at_acc, 6);
        hold_idx = -1; hold_len = 0;
        wait_pops(8, 200, "t4_pixels");
        check("t4_bursts", f_bursts, 2);

        // 5: restart with 3 beats outstanding and 2 pixels buffered
        ready_mode = 3;
        kick();
        k = 0;
        while (!(out_m == 3 && occ_m == 2) && k < 100) begin
            tick();
            k++;
        end
        check("t5_setup", {31'd0, out_m == 3 && occ_m == 2}, 32'd1);
        ready_mode = 1;
        kick();
        check("t5_valid_drop", {31'd0, pixel_valid}, 32'd0);
        wait_pops(8, 200, "t5_pixels");
        check("t5_first_addr", b_addr[0], 32'h100);
        check("t5_out_at_first", out_at_first, 0);
        check("t5_bursts", f_bursts, 2);

        // 6: random backpressure on both sides over several frames
        ready_mode = 2;
        wr_rand = 1'b1;
        viol = 0;
        for (int f = 0; f < 3; f++) begin
            kick();
            wait_pops(8, 2000, "t6_pixels");
            repeat (10) tick();
            check("t6_bursts", f_bursts, 2);
        end
        check("t6_credit", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
